// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC, interrupt/exception arbitration, eret, mtc0/mfc0.
// Optional PRId register (Rd=15) is enabled by defining CP0_PRID_EN.
module cp0_exception_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE = 32'h2022_0BAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_EXLClr,
    input  logic        M_CP0Write,
    input  logic [4:0]  M_Rd,
    input  logic [31:0] M_WData,
    input  logic [5:0]  HWInt,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] CP0Out,
    output logic        EXL
);

    localparam logic [4:0] RD_SR    = 5'd12;
    localparam logic [4:0] RD_CAUSE = 5'd13;
    localparam logic [4:0] RD_EPC   = 5'd14;
    localparam logic [4:0] RD_PRID  = 5'd15;

    // The pipeline registers own the redirect; these only reject nonsensical constants.
    if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_handler
        $error("HANDLER_PC must be word-aligned");
    end
    if (PRID_VALUE == 32'h0) begin : g_bad_prid
        $error("PRID_VALUE must be nonzero");
    end

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic int_req, exc_req;
    logic [31:0] sr_val, cause_val;

    assign int_req = sr_ie_q & ~sr_exl_q & |(HWInt & sr_im_q);
    assign exc_req = ~sr_exl_q & (M_ExcCode != 5'd0);
    assign Req     = int_req | exc_req;
    assign EPCOut  = epc_q;
    assign EXL     = sr_exl_q;

    assign sr_val    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    assign cause_val = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        // Req dominates eret, which dominates mtc0.
        if (Req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = M_BD;
            cause_exc_d = int_req ? 5'd0 : M_ExcCode;
            epc_d       = M_BD ? (M_PC - 32'd4) : M_PC;
        end else if (M_EXLClr) begin
            sr_exl_d = 1'b0;
        end else if (M_CP0Write) begin
            case (M_Rd)
                RD_SR: begin
                    sr_im_d  = M_WData[15:10];
                    sr_exl_d = M_WData[1];
                    sr_ie_d  = M_WData[0];
                end
                RD_EPC:  epc_d = M_WData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        CP0Out = 32'h0;
        case (M_Rd)
            RD_SR:    CP0Out = sr_val;
            RD_CAUSE: CP0Out = cause_val;
            RD_EPC:   CP0Out = epc_q;
`ifdef CP0_PRID_EN
            RD_PRID:  CP0Out = PRID_VALUE;
`else
            RD_PRID:  CP0Out = 32'h0;
`endif
            default:  CP0Out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed, table-driven bench for cp0_exception_unit: each row is one cycle of inputs
// plus the outputs expected in that cycle (before the closing edge).
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  M_ExcCode;
    logic        M_EXLClr;
    logic        M_CP0Write;
    logic [4:0]  M_Rd;
    logic [31:0] M_WData;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] CP0Out;
    logic        EXL;

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h2022_0BAA;
`else
    localparam logic [31:0] PRID_EXP = 32'h0;
`endif

    cp0_exception_unit dut (
        .clk(clk), .reset(reset), .M_PC(M_PC), .M_BD(M_BD), .M_ExcCode(M_ExcCode),
        .M_EXLClr(M_EXLClr), .M_CP0Write(M_CP0Write), .M_Rd(M_Rd), .M_WData(M_WData),
        .HWInt(HWInt), .Req(Req), .EPCOut(EPCOut), .CP0Out(CP0Out), .EXL(EXL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd;
        logic        eclr;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [5:0]  hw;
        logic        req;
        logic [31:0] cp0;
        logic [31:0] epc;
        logic        exl;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(input int rst, input int exc, input logic [31:0] pc, input int bd,
                       input int eclr, input int wr, input int rd, input logic [31:0] wd,
                       input int hw, input int req, input logic [31:0] cp0,
                       input logic [31:0] epc, input int exl);
        vec_t v;
        v.rst = 1'(rst); v.exc = 5'(exc); v.pc = pc; v.bd = 1'(bd);
        v.eclr = 1'(eclr); v.wr = 1'(wr); v.rd = 5'(rd); v.wd = wd; v.hw = 6'(hw);
        v.req = 1'(req); v.cp0 = cp0; v.epc = epc; v.exl = 1'(exl);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; M_ExcCode = v.exc; M_PC = v.pc; M_BD = v.bd; M_EXLClr = v.eclr;
        M_CP0Write = v.wr; M_Rd = v.rd; M_WData = v.wd; HWInt = v.hw;
    endtask

    initial begin
        vec_t idle;
        idle = '{rst: 1'b0, exc: 5'd0, pc: 32'h0, bd: 1'b0, eclr: 1'b0, wr: 1'b0, rd: 5'd0,
                 wd: 32'h0, hw: 6'd0, req: 1'b0, cp0: 32'h0, epc: 32'h0, exl: 1'b0};

        //   rst exc pc            bd ec wr rd wd            hw  req cp0           epc           exl
        add(0, 0,  32'h0,         0, 0, 0, 12, 32'h0,        0,  0, 32'h0,        32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h0,        32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 14, 32'h0,        0,  0, 32'h0,        32'h0,        0);
        add(0, 4,  32'h3010,      0, 0, 0, 13, 32'h0,        0,  1, 32'h0,        32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h10,       32'h3010,     1);
        add(0, 10, 32'h0,         0, 0, 0, 12, 32'h0,        0,  0, 32'h2,        32'h3010,     1);
        add(0, 0,  32'h0,         0, 1, 0, 14, 32'h0,        0,  0, 32'h3010,     32'h3010,     1);
        add(0, 10, 32'h3020,      1, 0, 0, 12, 32'h0,        0,  1, 32'h0,        32'h3010,     0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h8000_0028, 32'h301C,    1);
        add(0, 0,  32'h0,         0, 1, 0, 12, 32'h0,        0,  0, 32'h2,        32'h301C,     1);
        add(0, 0,  32'h0,         0, 0, 1, 12, 32'h401,      1,  0, 32'h0,        32'h301C,     0);
        add(0, 12, 32'h3040,      0, 0, 0, 13, 32'h0,        1,  1, 32'h8000_0428, 32'h301C,    0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        1,  0, 32'h400,      32'h3040,     1);
        add(0, 0,  32'h0,         0, 1, 0, 12, 32'h0,        1,  0, 32'h403,      32'h3040,     1);
        add(0, 0,  32'h3050,      0, 0, 0, 14, 32'h0,        1,  1, 32'h3040,     32'h3040,     0);
        add(0, 0,  32'h0,         0, 1, 0, 13, 32'h0,        0,  0, 32'h400,      32'h3050,     1);
        add(0, 4,  32'h3060,      0, 0, 1, 14, 32'h1234,     0,  1, 32'h3050,     32'h3050,     0);
        add(0, 0,  32'h0,         0, 0, 0, 14, 32'h0,        0,  0, 32'h3060,     32'h3060,     1);
        add(0, 0,  32'h0,         0, 0, 1, 13, 32'hFFFF_FFFF, 0, 0, 32'h10,       32'h3060,     1);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h10,       32'h3060,     1);
        add(0, 0,  32'h0,         0, 0, 1, 12, 32'hFFFF_FFFF, 0, 0, 32'h403,      32'h3060,     1);
        add(0, 0,  32'h0,         0, 0, 0, 12, 32'h0,        0,  0, 32'hFC03,     32'h3060,     1);
        add(0, 0,  32'h0,         0, 0, 1, 12, 32'h0,        0,  0, 32'hFC03,     32'h3060,     1);
        add(0, 4,  32'h0,         1, 0, 0, 14, 32'h0,        0,  1, 32'h3060,     32'h3060,     0);
        add(0, 0,  32'h0,         0, 0, 0, 14, 32'h0,        0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
        add(0, 0,  32'h0,         0, 0, 0, 15, 32'h0,        0,  0, PRID_EXP,     32'hFFFF_FFFC, 1);
        add(0, 0,  32'h0,         0, 0, 1, 14, 32'h1234,     0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
        add(0, 0,  32'h0,         0, 0, 0, 14, 32'h0,        0,  0, 32'h1234,     32'h1234,     1);
        add(0, 0,  32'h0,         0, 0, 0, 0,  32'h0,        0,  0, 32'h0,        32'h1234,     1);
        add(0, 0,  32'h0,         0, 0, 1, 15, 32'hDEAD,     0,  0, PRID_EXP,     32'h1234,     1);
        add(0, 0,  32'h0,         0, 0, 0, 15, 32'h0,        0,  0, PRID_EXP,     32'h1234,     1);
        add(0, 0,  32'h0,         0, 1, 0, 12, 32'h0,        0,  0, 32'h2,        32'h1234,     1);
        // reset concurrent with a live exception request: reset wins
        add(1, 4,  32'h5000,      0, 0, 0, 12, 32'h0,        0,  1, 32'h0,        32'h1234,     0);
        add(0, 0,  32'h0,         0, 0, 0, 14, 32'h0,        0,  0, 32'h0,        32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h0,        32'h0,        0);
        // Cause.IP follows HWInt with one cycle of latency
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,     6'h20, 0, 32'h0,        32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h8000,     32'h0,        0);
        add(0, 0,  32'h0,         0, 0, 0, 13, 32'h0,        0,  0, 32'h0,        32'h0,        0);

        // Initial one-cycle reset from unknown state
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            chk("req",    i, {31'b0, Req},  {31'b0, vecs[i].req});
            chk("cp0out", i, CP0Out,        vecs[i].cp0);
            chk("epcout", i, EPCOut,        vecs[i].epc);
            chk("exl",    i, {31'b0, EXL},  {31'b0, vecs[i].exl});
            @(negedge clk);
        end

        // Req is combinational: it must follow M_ExcCode within the same cycle.
        drive(idle);
        M_ExcCode = 5'd7;
        #1;
        chk("req_comb_on", -1, {31'b0, Req}, 32'd1);
        M_ExcCode = 5'd0;
        #1;
        chk("req_comb_off", -1, {31'b0, Req}, 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
